// File: rtl/ok_dram_byte_reader_pkg.sv
// ---------------------------------------------------------------------------
// ok_dram_byte_reader_pkg
// Shared definitions for the okDRAM16X8D read-side sequencer: default buffer
// geometry and the sequencer state encoding.
// ---------------------------------------------------------------------------
package ok_dram_byte_reader_pkg;

  localparam int ADDR_W = 4;            // buffer address width
  localparam int DATA_W = 8;            // buffer byte width
  localparam int DEPTH  = 2 ** ADDR_W;  // buffer entries

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ok_dram_byte_reader_if.sv
// ---------------------------------------------------------------------------
// ok_dram_byte_reader_if
// Valid/ready byte stream leaving the buffer reader.
//   m_data  : output byte (driven by master)
//   m_valid : m_data valid (driven by master)
//   m_ready : consumer accepts when m_valid & m_ready (driven by slave)
// ---------------------------------------------------------------------------
interface ok_dram_byte_reader_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/ok_dram_byte_reader.sv
// ---------------------------------------------------------------------------
// ok_dram_byte_reader
// Read-side sequencer for the 16x8 distributed byte buffer. Walks the
// buffer's asynchronous read port from a start address (wrapping modulo the
// depth) and streams a run of bytes out over a valid/ready handshake.
// Ports:
//   i_clk        : clock, all logic on the rising edge
//   i_reset      : synchronous active-high reset
//   i_start      : begin a run (sampled only in IDLE)
//   i_start_addr : first buffer address of the run
//   i_count      : bytes to read, 0..DEPTH; larger values clamp to DEPTH
//   i_abort      : synchronous cancel of the current run
//   o_ram_addr   : buffer read address (addrB)
//   i_ram_data   : buffer read data (doutB), combinational of o_ram_addr
//   m_if         : output byte stream (master side)
//   o_busy       : high while in RUN or DRAIN
//   o_done       : one-cycle pulse after the last byte is accepted
// ---------------------------------------------------------------------------
module ok_dram_byte_reader
  import ok_dram_byte_reader_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W,
  parameter int DATA_W_P = DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_W_P-1:0]   i_start_addr,
  input  logic [ADDR_W_P:0]     i_count,
  input  logic                  i_abort,
  output logic [ADDR_W_P-1:0]   o_ram_addr,
  input  logic [DATA_W_P-1:0]   i_ram_data,
  ok_dram_byte_reader_if.master m_if,
  output logic                  o_busy,
  output logic                  o_done
);

  // Full-buffer run length; requests above it are clamped.
  localparam logic [ADDR_W_P:0]   MAX_CNT = {1'b1, {ADDR_W_P{1'b0}}};
  localparam logic [ADDR_W_P:0]   REM_ONE = {{ADDR_W_P{1'b0}}, 1'b1};
  localparam logic [ADDR_W_P-1:0] PTR_ONE = {{(ADDR_W_P-1){1'b0}}, 1'b1};

  state_e                r_state;
  logic [ADDR_W_P-1:0]   r_rd_ptr;
  logic [ADDR_W_P:0]     r_remaining;
  logic [DATA_W_P-1:0]   r_m_data;
  logic                  r_m_valid;
  logic                  r_busy;
  logic                  r_done;

  state_e                w_state_nx;
  logic [ADDR_W_P-1:0]   w_rd_ptr_nx;
  logic [ADDR_W_P:0]     w_remaining_nx;
  logic [DATA_W_P-1:0]   w_m_data_nx;
  logic                  w_m_valid_nx;
  logic                  w_load;
  logic                  w_accept;

  assign w_accept = r_m_valid & m_if.m_ready;
  // A new byte is captured whenever the output slot is free or being emptied.
  assign w_load   = (r_state == ST_RUN) & (~r_m_valid | m_if.m_ready) &
                    (r_remaining != {(ADDR_W_P+1){1'b0}});

  // Next-state and datapath update logic.
  always_comb begin
    w_state_nx     = r_state;
    w_rd_ptr_nx    = r_rd_ptr;
    w_remaining_nx = r_remaining;
    w_m_data_nx    = r_m_data;
    w_m_valid_nx   = r_m_valid;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_count != {(ADDR_W_P+1){1'b0}}) begin
            w_state_nx     = ST_RUN;
            w_rd_ptr_nx    = i_start_addr;
            w_remaining_nx = (i_count > MAX_CNT) ? MAX_CNT : i_count;
          end else begin
            w_state_nx     = ST_DONE;
          end
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_load) begin
          w_m_data_nx    = i_ram_data;
          w_m_valid_nx   = 1'b1;
          w_rd_ptr_nx    = r_rd_ptr + PTR_ONE;
          w_remaining_nx = r_remaining - REM_ONE;
          w_state_nx     = (r_remaining == REM_ONE) ? ST_DRAIN : ST_RUN;
        end else if (w_accept) begin
          w_m_valid_nx = 1'b0;
        end else begin
          w_m_valid_nx = r_m_valid;
        end
      end
      ST_DRAIN: begin
        if (w_accept) begin
          w_state_nx   = ST_DONE;
          w_m_valid_nx = 1'b0;
        end else begin
          w_state_nx   = ST_DRAIN;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx   = ST_IDLE;
        w_m_valid_nx = 1'b0;
      end
    endcase

    // Abort cancels from any state and suppresses the done pulse.
    if (i_abort) begin
      w_state_nx     = ST_IDLE;
      w_m_valid_nx   = 1'b0;
      w_remaining_nx = {(ADDR_W_P+1){1'b0}};
    end else begin
      w_state_nx = w_state_nx;
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_rd_ptr    <= {ADDR_W_P{1'b0}};
      r_remaining <= {(ADDR_W_P+1){1'b0}};
      r_m_data    <= {DATA_W_P{1'b0}};
      r_m_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_rd_ptr    <= w_rd_ptr_nx;
      r_remaining <= w_remaining_nx;
      r_m_data    <= w_m_data_nx;
      r_m_valid   <= w_m_valid_nx;
      r_busy      <= (w_state_nx == ST_RUN) | (w_state_nx == ST_DRAIN);
      r_done      <= (w_state_nx == ST_DONE);
    end
  end

  assign o_ram_addr   = r_rd_ptr;
  assign m_if.m_data  = r_m_data;
  assign m_if.m_valid = r_m_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
